// File: rtl/gpu_cmd_sequencer.sv
// Command FIFO and issue sequencer for the fill/blit engine: queues host commands,
// issues them one at a time with stable registered operands, and tracks completions/errors.
module gpu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [8:0]               cmd_x1,
  input  logic [7:0]               cmd_y1,
  input  logic [8:0]               cmd_x2,
  input  logic [7:0]               cmd_y2,
  input  logic [8:0]               cmd_w,
  input  logic [7:0]               cmd_h,
  input  logic                     cmd_fill_value,
  output logic [8:0]               eng_x1,
  output logic [7:0]               eng_y1,
  output logic [8:0]               eng_x2,
  output logic [7:0]               eng_y2,
  output logic [8:0]               eng_w,
  output logic [7:0]               eng_h,
  output logic                     eng_fill_value,
  output logic                     eng_start_fill,
  output logic                     eng_start_blit,
  input  logic                     eng_busy,
  input  logic                     eng_error,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic                     idle,
  output logic                     done_pulse,
  output logic [CW-1:0]            done_count,
  output logic                     err_sticky,
  input  logic                     err_clear
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_FILL = 2'd1;
  localparam logic [1:0] OP_BLIT = 2'd2;
  localparam logic [1:0] OP_RSVD = 2'd3;

  typedef struct packed {
    logic [1:0] op;
    logic [8:0] x1;
    logic [7:0] y1;
    logic [8:0] x2;
    logic [7:0] y2;
    logic [8:0] w;
    logic [7:0] h;
    logic       fv;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ACCEPT, S_RUN} state_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;
  state_t        state;
  logic          acc_wait;
  logic          retire, err_set;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = (state == S_ISSUE);
  assign head      = mem[rd_ptr];
  assign queue_count = count;
  assign idle      = empty && (state == S_IDLE) && !eng_busy;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op: cmd_op, x1: cmd_x1, y1: cmd_y1, x2: cmd_x2,
                               y2: cmd_y2, w: cmd_w, h: cmd_h, fv: cmd_fill_value};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ACCEPT spans two cycles: the engine samples start in the first, busy is visible in the second.
  always_comb begin
    retire  = 1'b0;
    err_set = 1'b0;
    case (state)
      S_ISSUE: begin
        retire  = (head.op == OP_NOP) || (head.op == OP_RSVD);
        err_set = (head.op == OP_RSVD);
      end
      S_ACCEPT: begin
        retire  = acc_wait && !eng_busy;
        err_set = acc_wait && !eng_busy && eng_error;
      end
      S_RUN:   retire = !eng_busy;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      acc_wait       <= 1'b0;
      eng_x1         <= '0;
      eng_y1         <= '0;
      eng_x2         <= '0;
      eng_y2         <= '0;
      eng_w          <= '0;
      eng_h          <= '0;
      eng_fill_value <= 1'b0;
      eng_start_fill <= 1'b0;
      eng_start_blit <= 1'b0;
      done_pulse     <= 1'b0;
      done_count     <= '0;
      err_sticky     <= 1'b0;
    end else begin
      eng_start_fill <= 1'b0;
      eng_start_blit <= 1'b0;
      done_pulse     <= retire;
      if (retire) done_count <= done_count + 1'b1;
      if (err_set)        err_sticky <= 1'b1;
      else if (err_clear) err_sticky <= 1'b0;

      case (state)
        S_IDLE: begin
          acc_wait <= 1'b0;
          if (!empty && !eng_busy) state <= S_ISSUE;
        end
        S_ISSUE: begin
          eng_x1         <= head.x1;
          eng_y1         <= head.y1;
          eng_x2         <= head.x2;
          eng_y2         <= head.y2;
          eng_w          <= head.w;
          eng_h          <= head.h;
          eng_fill_value <= head.fv;
          acc_wait       <= 1'b0;
          case (head.op)
            OP_FILL: begin eng_start_fill <= 1'b1; state <= S_ACCEPT; end
            OP_BLIT: begin eng_start_blit <= 1'b1; state <= S_ACCEPT; end
            default: state <= S_IDLE;
          endcase
        end
        S_ACCEPT: begin
          acc_wait <= 1'b1;
          if (acc_wait) state <= eng_busy ? S_RUN : S_IDLE;
        end
        S_RUN: begin
          if (!eng_busy) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gpu_cmd_sequencer.sv
// Scoreboard bench for gpu_cmd_sequencer with a behavioural fill/blit engine model.
module tb_gpu_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 cmd_valid = 1'b0;
  logic                 cmd_ready;
  logic [1:0]           cmd_op = '0;
  logic [8:0]           cmd_x1 = '0, cmd_x2 = '0, cmd_w = '0;
  logic [7:0]           cmd_y1 = '0, cmd_y2 = '0, cmd_h = '0;
  logic                 cmd_fill_value = 1'b0;
  logic [8:0]           eng_x1, eng_x2, eng_w;
  logic [7:0]           eng_y1, eng_y2, eng_h;
  logic                 eng_fill_value, eng_start_fill, eng_start_blit;
  logic                 eng_busy;
  logic                 eng_error = 1'b0;
  logic [$clog2(DEPTH):0] queue_count;
  logic                 idle, done_pulse, err_sticky;
  logic [CW-1:0]        done_count;
  logic                 err_clear = 1'b0;

  gpu_cmd_sequencer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x1(cmd_x1), .cmd_y1(cmd_y1), .cmd_x2(cmd_x2), .cmd_y2(cmd_y2),
    .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_fill_value(cmd_fill_value),
    .eng_x1(eng_x1), .eng_y1(eng_y1), .eng_x2(eng_x2), .eng_y2(eng_y2),
    .eng_w(eng_w), .eng_h(eng_h), .eng_fill_value(eng_fill_value),
    .eng_start_fill(eng_start_fill), .eng_start_blit(eng_start_blit),
    .eng_busy(eng_busy), .eng_error(eng_error),
    .queue_count(queue_count), .idle(idle), .done_pulse(done_pulse),
    .done_count(done_count), .err_sticky(err_sticky), .err_clear(err_clear)
  );

  typedef struct packed {
    logic [1:0] op;
    logic [8:0] x1;
    logic [7:0] y1;
    logic [8:0] x2;
    logic [7:0] y2;
    logic [8:0] w;
    logic [7:0] h;
    logic       fv;
  } op_t;

  op_t exp_q[$];
  int  n_chk = 0, n_pass = 0;
  int  n_start = 0, n_done = 0, n_busy = 0, n_hold = 0;
  int  exp_done = 0;
  int  busy_ovr = 0;
  int  eng_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Engine model (no reset): fill busy for its area, blit for w*h, bad fill corners rejected.
  always @(posedge clk) begin
    if (eng_start_fill || eng_start_blit) begin
      if (eng_start_fill && (eng_x1 > eng_x2 || eng_y1 > eng_y2)) begin
        eng_error <= 1'b1;
        eng_cnt   <= 0;
      end else begin
        eng_error <= 1'b0;
        eng_cnt   <= (busy_ovr != 0) ? busy_ovr :
                     eng_start_fill ? (int'(eng_x2) - int'(eng_x1) + 1) * (int'(eng_y2) - int'(eng_y1) + 1)
                                    : int'(eng_w) * int'(eng_h);
      end
    end else if (eng_cnt > 0) eng_cnt <= eng_cnt - 1;
  end
  assign eng_busy = (eng_cnt > 0);

  op_t held, got_op;
  bit  held_ok = 0;
  always @(negedge clk) begin
    if (rst) begin
      n_done  = 0;
      held_ok = 0;
    end else begin
      if (done_pulse) n_done++;
      if (eng_busy) n_busy++;
      got_op = '{op: eng_start_fill ? 2'd1 : (eng_start_blit ? 2'd2 : held.op),
                 x1: eng_x1, y1: eng_y1, x2: eng_x2, y2: eng_y2, w: eng_w, h: eng_h, fv: eng_fill_value};
      if (eng_start_fill || eng_start_blit) begin
        n_start++;
        chk("start_while_busy", eng_busy, 0);
        chk("start_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("issue_operands", got_op, exp_q.pop_front());
        held    = got_op;
        held_ok = 1;
      end else if (eng_busy && held_ok) begin
        n_hold++;
        chk("operand_hold", got_op, held);
      end
    end
  end

  task automatic push(input logic [1:0] op, input int x1, input int y1, input int x2,
                      input int y2, input int w, input int h, input logic fv);
    bit ok = 0;
    cmd_op = op; cmd_x1 = 9'(x1); cmd_y1 = 8'(y1); cmd_x2 = 9'(x2); cmd_y2 = 8'(y2);
    cmd_w = 9'(w); cmd_h = 8'(h); cmd_fill_value = fv;
    cmd_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk) ok = cmd_ready;
      @(posedge clk);
    end
    #1 cmd_valid = 1'b0;
    chk("push_accepted", ok, 1);
    if (ok) begin
      exp_done++;
      if (op == 2'd1 || op == 2'd2)
        exp_q.push_back('{op: op, x1: 9'(x1), y1: 8'(y1), x2: 9'(x2), y2: 8'(y2),
                          w: 9'(w), h: 8'(h), fv: fv});
    end
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 0;
    for (int i = 0; i < 600 && !ok; i++) @(negedge clk) ok = idle;
    chk(tag, ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_start(input string tag);
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) @(negedge clk) ok = eng_start_fill || eng_start_blit;
    chk(tag, ok, 1);
  endtask

  task automatic wait_busy(input string tag);
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) @(negedge clk) ok = eng_busy;
    chk(tag, ok, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int s0, b0, h0;
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_qcount", queue_count, 0);
    chk("rst_done_count", done_count, 0);
    chk("rst_err", err_sticky, 0);
    chk("rst_pulses", {eng_start_fill, eng_start_blit, done_pulse}, 0);
    chk("rst_operands", {eng_x1, eng_y1, eng_x2, eng_y2, eng_w, eng_h, eng_fill_value}, 0);
    rst = 1'b0;
    @(negedge clk) chk("rst_idle", idle, 1);
    @(posedge clk); #1;

    // single fill
    s0 = n_start; b0 = n_busy;
    push(2'd1, 1, 1, 3, 2, 0, 0, 1'b1);
    wait_idle("t1_idle");
    chk("t1_starts", n_start - s0, 1);
    chk("t1_busy_cycles", n_busy - b0, 6);
    chk("t1_done_count", done_count, 1);
    chk("t1_done_pulses", n_done, 1);
    chk("t1_err", err_sticky, 0);

    // queue fill behind a long operation
    busy_ovr = 20;
    push(2'd1, 0, 0, 1, 1, 0, 0, 1'b0);
    wait_busy("t2_busy");
    for (int i = 0; i < 4; i++) push(2'd1, i, i + 1, i + 5, i + 6, 0, 0, 1'(i));
    @(negedge clk);
    chk("t2_full_ready", cmd_ready, 0);
    chk("t2_full_count", queue_count, 4);
    wait_start("t2_first_pop");
    chk("t2_ready_back", cmd_ready, 1);
    chk("t2_count_after_pop", queue_count, 3);
    @(posedge clk); #1;
    wait_idle("t2_idle");
    busy_ovr = 0;
    chk("t2_done_count", done_count, CW'(exp_done));
    chk("t2_sb_drained", exp_q.size(), 0);

    // rejected command, then a good one, then clear vs set
    push(2'd1, 5, 0, 2, 0, 0, 0, 1'b1);
    wait_start("t3_start");
    seen = 0;
    for (int i = 0; i < 3 && !seen; i++) @(negedge clk) seen = done_pulse;
    chk("t3_reject_done", seen, 1);
    chk("t3_err_set", err_sticky, 1);
    @(posedge clk); #1;
    s0 = n_done;
    push(2'd1, 2, 0, 5, 0, 0, 0, 1'b1);
    wait_idle("t3_idle");
    chk("t3_good_done", n_done - s0, 1);
    err_clear = 1'b1; @(posedge clk); #1 err_clear = 1'b0;
    chk("t3_err_cleared", err_sticky, 0);
    push(2'd1, 7, 3, 1, 3, 0, 0, 1'b0);
    wait_start("t3_start2");
    @(posedge clk); #1 err_clear = 1'b1;
    @(posedge clk); #1 err_clear = 1'b0;
    @(negedge clk) chk("t3_set_wins", err_sticky, 1);
    @(posedge clk); #1;
    wait_idle("t3_idle2");
    chk("t3_done_count", done_count, CW'(exp_done));

    // NOP and reserved opcode
    err_clear = 1'b1; @(posedge clk); #1 err_clear = 1'b0;
    s0 = n_start;
    push(2'd0, 0, 0, 0, 0, 0, 0, 1'b0);
    wait_idle("t4_idle_nop");
    chk("t4_err_after_nop", err_sticky, 0);
    push(2'd3, 0, 0, 0, 0, 0, 0, 1'b0);
    wait_idle("t4_idle_rsvd");
    chk("t4_err_after_rsvd", err_sticky, 1);
    chk("t4_no_starts", n_start - s0, 0);
    chk("t4_done_count", done_count, CW'(exp_done));

    // blit operand hold with pushes arriving while busy
    h0 = n_hold;
    push(2'd2, 0, 0, 10, 10, 4, 2, 1'b0);
    wait_start("t5_start");
    @(posedge clk); #1;
    push(2'd1, 3, 4, 6, 4, 0, 0, 1'b1);
    push(2'd1, 0, 0, 0, 0, 0, 0, 1'b0);
    wait_idle("t5_idle");
    chk("t5_hold_cycles", (n_hold - h0) >= 8, 1);
    chk("t5_done_count", done_count, CW'(exp_done));

    // reset while engine busy with entries queued
    busy_ovr = 20;
    push(2'd1, 1, 1, 2, 2, 0, 0, 1'b1);
    wait_busy("t6_busy");
    push(2'd1, 4, 4, 5, 5, 0, 0, 1'b0);
    push(2'd2, 1, 2, 3, 4, 2, 2, 1'b0);
    busy_ovr = 0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    exp_done = 0;
    chk("t6_qcount", queue_count, 0);
    chk("t6_ready", cmd_ready, 1);
    chk("t6_done_count", done_count, 0);
    chk("t6_eng_still_busy", eng_busy, 1);
    push(2'd1, 3, 3, 4, 4, 0, 0, 1'b1);
    wait_idle("t6_idle");
    chk("t6_new_done_count", done_count, 1);
    chk("t6_new_done_pulses", n_done, 1);
    chk("t6_sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
